imem_arbiter: RTL and testbench

Shares the single-port, word-addressed instruction memory between two requesters: the CPU fetch stage (F port) and the debug/program loader (D port). Each cycle the arbiter grants at most one request and drives the memory address and write controls. It registers the asynchronous memory read data and returns it one cycle later. It also supports a debug lock for uninterrupted load bursts and flags misaligned or out-of-range accesses.

---
 rtl/imem_arbiter_if.sv | 43 ++++
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle of requester handshakes (fetch F, debug D) and the instruction-memory port.
// The arbiter takes the slave view; the requesters/memory model take the master view.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              locked;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_we, mem_wdata, locked
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_we, mem_wdata, locked
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter between fetch (F) and debug loader (D):
// round-robin grant, debug lock with idle timeout, 1-cycle registered responses.
module imem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    imem_arbiter_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic             r_last_gnt_d;
    logic [CNT_W-1:0] r_idle_cnt;

    logic             r_f_rvalid;
    logic [31:0]      r_f_rdata;
    logic             r_f_err;
    logic             r_d_rvalid;
    logic [31:0]      r_d_rdata;
    logic             r_d_err;

    logic             w_f_gnt;
    logic             w_d_gnt;
    logic             w_f_err;
    logic             w_d_err;
    logic             w_timeout;

    // Misaligned or beyond the 2^ADDR_W-word window.
    assign w_f_err = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr[31:ADDR_W+2] != '0);
    assign w_d_err = (bus.d_addr[1:0] != 2'b00) || (bus.d_addr[31:ADDR_W+2] != '0);

    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_d_gnt = bus.d_req;
        end else if (bus.f_req && bus.d_req) begin
            // Tie: the port that lost most recently wins.
            if (r_last_gnt_d) w_f_gnt = 1'b1;
            else              w_d_gnt = 1'b1;
        end else begin
            w_f_gnt = bus.f_req;
            w_d_gnt = bus.d_req;
        end
    end

    assign w_timeout = !bus.d_req && (r_idle_cnt >= CNT_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_UNLOCKED: if (w_d_gnt && bus.d_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED:   if ((w_d_gnt && !bus.d_lock) || w_timeout) w_state_nxt = ST_UNLOCKED;
            default:     w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    // Consecutive idle-D cycle counter, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 r_idle_cnt <= '0;
        else if (bus.d_req)                        r_idle_cnt <= '0;
        else if (r_idle_cnt != CNT_W'(LOCK_TIMEOUT)) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt_d <= 1'b1;
            r_f_rvalid   <= 1'b0;
            r_f_rdata    <= '0;
            r_f_err      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
            r_d_err      <= 1'b0;
        end else begin
            r_f_rvalid <= w_f_gnt;
            r_d_rvalid <= w_d_gnt;
            r_f_err    <= w_f_gnt & w_f_err;
            r_d_err    <= w_d_gnt & w_d_err;
            if (w_f_gnt) r_f_rdata <= w_f_err ? 32'd0 : bus.mem_rdata;
            if (w_d_gnt) r_d_rdata <= (w_d_err || bus.d_we) ? 32'd0 : bus.mem_rdata;
            if (w_f_gnt || w_d_gnt) r_last_gnt_d <= w_d_gnt;
        end
    end

    assign bus.f_gnt     = w_f_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_addr  = w_d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.f_addr[ADDR_W+1:2];
    assign bus.mem_we    = w_d_gnt & bus.d_we & ~w_d_err;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.f_rvalid  = r_f_rvalid;
    assign bus.f_rdata   = r_f_rdata;
    assign bus.f_err     = r_f_err;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_err     = r_d_err;
    assign bus.locked    = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: expected responses are queued at grant time
// and popped when the port's rvalid appears one cycle later.
module tb_imem_arbiter;
    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned LOCK_TIMEOUT = 16;
    localparam int unsigned DEPTH        = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    rsp_t f_q[$];
    rsp_t d_q[$];
    logic [31:0] mem [0:DEPTH-1];

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read, synchronous-write memory model.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic fr, input logic [31:0] fa, input logic dr, input logic dwe,
                           input logic dl, input logic [31:0] da, input logic [31:0] dwd);
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_lock  = dl;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
    endtask

    // One cycle: check grants/strobe, queue expected responses, clock, check responses and lock.
    task automatic step(input logic eg_f, input logic eg_d, input logic e_we,
                        input logic [31:0] f_dat, input logic f_er,
                        input logic [31:0] d_dat, input logic d_er, input logic e_lk);
        rsp_t r;
        #1;
        chk1("f_gnt", bus.f_gnt, eg_f);
        chk1("d_gnt", bus.d_gnt, eg_d);
        chk1("mem_we", bus.mem_we, e_we);
        if (eg_f) f_q.push_back({f_dat, f_er});
        if (eg_d) d_q.push_back({d_dat, d_er});
        @(posedge clk);
        #1;
        chk1("f_rvalid", bus.f_rvalid, eg_f);
        chk1("d_rvalid", bus.d_rvalid, eg_d);
        chk1("locked", bus.locked, e_lk);
        if (bus.f_rvalid) begin
            if (f_q.size() != 0) begin
                r = f_q.pop_front();
                chk("f_rdata", bus.f_rdata, r.data);
                chk1("f_err", bus.f_err, r.err);
            end else chk1("f_spurious_rvalid", bus.f_rvalid, 1'b0);
        end
        if (bus.d_rvalid) begin
            if (d_q.size() != 0) begin
                r = d_q.pop_front();
                chk("d_rdata", bus.d_rdata, r.data);
                chk1("d_err", bus.d_err, r.err);
            end else chk1("d_spurious_rvalid", bus.d_rvalid, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'hA500_0000 | 32'(i);
        mem[0] <= 32'h2002_0005;
        mem[1] <= 32'h2003_000C;
        mem[2] <= 32'h0043_0820;

        @(posedge clk);
        #1;
        chk1("rst_f_rvalid", bus.f_rvalid, 1'b0);
        chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
        chk1("rst_locked", bus.locked, 1'b0);
        chk("rst_f_rdata", bus.f_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // F-only reads
        set_req(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h2002_0005, 0, 32'h0, 0, 0);
        set_req(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h2003_000C, 0, 32'h0, 0, 0);
        set_req(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0043_0820, 0, 32'h0, 0, 0);

        // D-only read so the following tie starts with F
        set_req(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h2002_0005, 0, 0);

        // Continuous tie: F,D,F,D,F
        set_req(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step(1, 0, 0, 32'hA500_0004, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'hA500_0008, 0, 0);
        step(1, 0, 0, 32'hA500_0004, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'hA500_0008, 0, 0);
        step(1, 0, 0, 32'hA500_0004, 0, 32'h0, 0, 0);

        // Locked write burst with F waiting
        set_req(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        step(0, 1, 1, 32'h0, 0, 32'h0, 0, 1);
        set_req(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF);
        step(0, 1, 1, 32'h0, 0, 32'h0, 0, 1);
        set_req(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h48, 32'hDEAD_BEEF);
        step(0, 1, 1, 32'h0, 0, 32'h0, 0, 0);
        set_req(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);

        // Lock held then released by idle timeout
        set_req(1'b1, 32'h48, 1'b1, 1'b1, 1'b1, 32'h4C, 32'hCAFE_F00D);
        step(0, 1, 1, 32'h0, 0, 32'h0, 0, 1);
        set_req(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < int'(LOCK_TIMEOUT); i++)
            step(0, 0, 0, 32'h0, 0, 32'h0, 0, (i < int'(LOCK_TIMEOUT) - 1));
        step(1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
        set_req(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'hCAFE_F00D, 0, 32'h0, 0, 0);

        // Error accesses
        set_req(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h0, 0, 0);
        set_req(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h1234_5678);
        step(0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        set_req(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h2002_0005, 0, 32'h0, 0, 0);

        // Async reset right after a locked D grant
        set_req(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h50, 32'h55AA_55AA);
        step(0, 1, 1, 32'h0, 0, 32'h0, 0, 1);
        reset = 1'b1;
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("arst_d_rvalid", bus.d_rvalid, 1'b0);
        chk1("arst_locked", bus.locked, 1'b0);
        @(posedge clk);
        #1;
        chk1("arst_hold_d_rvalid", bus.d_rvalid, 1'b0);
        reset = 1'b0;
        set_req(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        step(1, 0, 0, 32'hA500_0004, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'hA500_0008, 0, 0);
        set_req(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);

        chk("f_q_drained", 32'(f_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
